// File: rtl/loop_lc_ctrl.sv
// Modulo-scheduled loop controller: paces op pulses every II cycles, tracks the loop counter, drains epilogue stages.
// Optional LOOP_LC_CTRL_STALL_EN adds a stall input that freezes all progress and suppresses op.
module loop_lc_ctrl #(
    parameter int unsigned LCWIDTH  = 16,
    parameter int unsigned IIWIDTH  = 4,
    parameter int unsigned ESCWIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef LOOP_LC_CTRL_STALL_EN
    input  logic                stall,
`endif
    input  logic                start,
    input  logic [LCWIDTH-1:0]  trip_count,
    input  logic [IIWIDTH-1:0]  ii,
    input  logic [ESCWIDTH-1:0] esc,
    output logic                op,
    output logic                running,
    output logic                enable,
    output logic [LCWIDTH-1:0]  lc,
    input  logic [LCWIDTH-1:0]  lc_in,
    input  logic                lc_wen,
    input  logic                p,
    input  logic                p_en,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KERNEL = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [LCWIDTH-1:0]  lc_q, lc_d;
    logic [IIWIDTH-1:0]  ii_q, ii_d;
    logic [IIWIDTH-1:0]  phase_q, phase_d;
    logic [ESCWIDTH-1:0] esc_q, esc_d;
    logic                stall_w;
    logic                active_w;
    logic                op_w;

`ifdef LOOP_LC_CTRL_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // op is decoded from registered state only; stall is the sole gating input
    assign active_w = (state_q == KERNEL) || (state_q == DRAIN);
    assign op_w     = active_w && (phase_q == ii_q - IIWIDTH'(1)) && !stall_w;
    assign op       = op_w;
    assign lc       = lc_q;

    always_comb begin
        state_d = state_q;
        lc_d    = lc_q;
        ii_d    = ii_q;
        phase_d = phase_q;
        esc_d   = esc_q;
        if (!stall_w) begin
            if (active_w) begin
                phase_d = op_w ? '0 : phase_q + IIWIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (trip_count != '0) begin
                            lc_d    = trip_count - LCWIDTH'(1);
                            ii_d    = (ii == '0) ? IIWIDTH'(1) : ii;
                            esc_d   = esc;
                            phase_d = '0;
                            state_d = KERNEL;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                KERNEL: begin
                    if (lc_wen) begin
                        lc_d = lc_in;
                    end
                    if (op_w && p_en && !p) begin
                        state_d = (esc_q == '0) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    // esc_q doubles as the epilogue down-counter
                    if (op_w) begin
                        esc_d = esc_q - ESCWIDTH'(1);
                        if (esc_q == ESCWIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lc_q    <= '0;
            ii_q    <= '0;
            phase_q <= '0;
            esc_q   <= '0;
            running <= 1'b0;
            enable  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            lc_q    <= lc_d;
            ii_q    <= ii_d;
            phase_q <= phase_d;
            esc_q   <= esc_d;
            running <= (state_d == KERNEL) || (state_d == DRAIN);
            enable  <= (state_d == KERNEL);
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_loop_lc_ctrl.sv
// Directed bench for loop_lc_ctrl with a behavioural branch unit; define LOOP_LC_CTRL_STALL_EN to add the stall case.
module tb_loop_lc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] trip_count;
    logic [3:0]  ii;
    logic [3:0]  esc;
    logic        op, running, enable, busy, done;
    logic [15:0] lc;
    logic [15:0] lc_in;
    logic        lc_wen, p, p_en;
    logic        stall;

    int n_chk  = 0;
    int n_pass = 0;

    loop_lc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef LOOP_LC_CTRL_STALL_EN
        .stall      (stall),
`endif
        .start      (start),
        .trip_count (trip_count),
        .ii         (ii),
        .esc        (esc),
        .op         (op),
        .running    (running),
        .enable     (enable),
        .lc         (lc),
        .lc_in      (lc_in),
        .lc_wen     (lc_wen),
        .p          (p),
        .p_en       (p_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Branch unit: decrement lc and keep looping while lc > 0
    task automatic branch_unit();
        if (op && enable) begin
            lc_wen = 1'b1;
            lc_in  = (lc != 16'd0) ? lc - 16'd1 : lc;
            p_en   = 1'b1;
            p      = (lc != 16'd0);
        end else begin
            lc_wen = 1'b0;
            lc_in  = 16'd0;
            p_en   = 1'b0;
            p      = 1'b0;
        end
    endtask

    task automatic run_loop(input logic [15:0] tc, input logic [3:0] iiv, input logic [3:0] escv,
                            input bit hold_start, input bit do_stall,
                            output int n_op, output int first_op, output int done_cyc,
                            output int n_en, output int n_run, output int n_busy,
                            output logic [47:0] lc_trace);
        n_op = 0; first_op = 0; done_cyc = 0; n_en = 0; n_run = 0; n_busy = 0;
        lc_trace = '0;
        start = 1'b1; trip_count = tc; ii = iiv; esc = escv;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            stall = do_stall && (k <= 3);
            #1;
            if (op) begin
                n_op++;
                if (first_op == 0) first_op = k;
                lc_trace = {lc_trace[31:0], lc};
            end
            if (enable)  n_en++;
            if (running) n_run++;
            if (busy)    n_busy++;
            branch_unit();
            if (done) begin
                done_cyc = k;
                start = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; stall = 1'b0;
        lc_wen = 1'b0; p_en = 1'b0; p = 1'b0;
        @(posedge clk); #1;
    endtask

    int          n_op, first_op, done_cyc, n_en, n_run, n_busy, nops, bad;
    logic [47:0] lc_trace;

    initial begin
        rst_n = 1'b0; start = 1'b0; trip_count = '0; ii = '0; esc = '0;
        lc_in = '0; lc_wen = 1'b0; p = 1'b0; p_en = 1'b0; stall = 1'b0;
        #1;
        check("reset_outputs", {op, running, enable, busy, done, lc}, 64'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // trip 3, ii 2, esc 0; start held high to show it is ignored outside IDLE
        run_loop(16'd3, 4'd2, 4'd0, 1'b1, 1'b0, n_op, first_op, done_cyc, n_en, n_run, n_busy, lc_trace);
        check("t1_ops", n_op, 3);
        check("t1_first_op", first_op, 2);
        check("t1_lc_trace", lc_trace, {16'd2, 16'd1, 16'd0});
        check("t1_done_cycle", done_cyc, 7);
        check("t1_busy_cycles", n_busy, 7);
        check("t1_idle_after", {busy, running, done}, 64'd0);

        // trip 2, ii 1, esc 2: four back-to-back ops
        run_loop(16'd2, 4'd1, 4'd2, 1'b0, 1'b0, n_op, first_op, done_cyc, n_en, n_run, n_busy, lc_trace);
        check("t2_ops", n_op, 4);
        check("t2_first_op", first_op, 1);
        check("t2_enable_cycles", n_en, 2);
        check("t2_running_cycles", n_run, 4);
        check("t2_done_cycle", done_cyc, 5);

        // trip 0: straight to DONE
        run_loop(16'd0, 4'd3, 4'd2, 1'b0, 1'b0, n_op, first_op, done_cyc, n_en, n_run, n_busy, lc_trace);
        check("t3_ops", n_op, 0);
        check("t3_busy_cycles", n_busy, 1);
        check("t3_done_cycle", done_cyc, 1);
        check("t3_running_cycles", n_run, 0);

        // ii 0 treated as 1
        run_loop(16'd1, 4'd0, 4'd1, 1'b0, 1'b0, n_op, first_op, done_cyc, n_en, n_run, n_busy, lc_trace);
        check("t4_ops", n_op, 2);
        check("t4_first_op", first_op, 1);
        check("t4_done_cycle", done_cyc, 3);

        // mid-loop reset after second op
        start = 1'b1; trip_count = 16'd5; ii = 4'd3; esc = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        nops = 0;
        for (int k = 1; k <= 40; k++) begin
            if (op) nops++;
            if (nops >= 2) break;
            branch_unit();
            @(posedge clk); #1;
        end
        check("t5_ops_before_reset", nops, 2);
        check("t5_lc_before_reset", lc, 16'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_outputs_in_reset", {op, running, enable, busy, done, lc}, 64'd0);
        lc_wen = 1'b0; p_en = 1'b0; p = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (done || busy || op) bad++;
        end
        check("t5_quiet_after_reset", bad, 0);
        run_loop(16'd5, 4'd3, 4'd0, 1'b0, 1'b0, n_op, first_op, done_cyc, n_en, n_run, n_busy, lc_trace);
        check("t5_rerun_ops", n_op, 5);
        check("t5_rerun_first_op", first_op, 3);
        check("t5_rerun_done_cycle", done_cyc, 16);

`ifdef LOOP_LC_CTRL_STALL_EN
        // stall over cycles 1..3 pushes the first op from cycle 2 to cycle 5
        run_loop(16'd2, 4'd2, 4'd0, 1'b0, 1'b1, n_op, first_op, done_cyc, n_en, n_run, n_busy, lc_trace);
        check("t6_stall_ops", n_op, 2);
        check("t6_stall_first_op", first_op, 5);
        check("t6_stall_done_cycle", done_cyc, 8);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
